// File: rtl/serial_adder_ctrl.sv
// Purpose : bit-serial WIDTH-bit unsigned adder that reuses one full_adder cell, LSB first.
// Latency : WIDTH clock edges from the accepting start edge to result valid, which is flagged by done_out.
// Backpressure: start_in is accepted only in IDLE or DONE and ignored in RUN; there is no queueing.
//
// Ports:
//   clk_in, rst_in        : clock, asynchronous active-high reset
//   start_in              : request, sampled in IDLE/DONE
//   a_in, b_in, c_in      : operands and carry-in, captured on the accepting edge
//   busy_out              : high while bits are being processed
//   done_out              : one-cycle pulse, result valid in the same cycle
//   sum_out, car_out      : registered result of the last completed add

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             car_out
);
    // One spare count value so the counter cannot wrap inside an operation.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cy_q, cy_d;
    logic             car_q, car_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] s_next;

    full_adder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (cy_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
    // Written as shift/or so it stays legal when WIDTH is 1.
    assign s_next = (s_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        cy_d    = cy_q;
        car_d   = car_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    a_sh_d  = a_in;
                    b_sh_d  = b_in;
                    cy_d    = c_in;
                    s_sh_d  = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                s_sh_d = s_next;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cy_d   = fa_c;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Publish straight from the adder so the last bit is included.
                    sum_d   = s_next;
                    car_d   = fa_c;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cy_q    <= 1'b0;
            car_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            cy_q    <= cy_d;
            car_q   <= car_d;
            cnt_q   <= cnt_d;
        end
    end

    // DONE lasts exactly one cycle, so decoding it yields the done pulse.
    assign busy_out = (state_q == S_RUN);
    assign done_out = (state_q == S_DONE);
    assign sum_out  = sum_q;
    assign car_out  = car_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Purpose : exercises serial_adder_ctrl at WIDTH=8 and WIDTH=1 against an arithmetic reference.
// Latency : expects done exactly WIDTH edges after the accepting edge.
// Backpressure: covers starts ignored in RUN, back-to-back starts in DONE, and mid-run reset.

module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       c;
    logic       busy, done, car;
    logic [7:0] sum;

    logic       start1, a1, b1, c1;
    logic       busy1, done1, car1;
    logic [0:0] sum1;

    int         n_chk  = 0;
    int         n_pass = 0;

    // Result the 8-bit DUT is expected to be holding.
    logic [7:0] exp_sum = 8'h00;
    logic       exp_car = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk_in   (clk),
        .rst_in   (rst),
        .start_in (start),
        .a_in     (a),
        .b_in     (b),
        .c_in     (c),
        .busy_out (busy),
        .done_out (done),
        .sum_out  (sum),
        .car_out  (car)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk_in   (clk),
        .rst_in   (rst),
        .start_in (start1),
        .a_in     (a1),
        .b_in     (b1),
        .c_in     (c1),
        .busy_out (busy1),
        .done_out (done1),
        .sum_out  (sum1),
        .car_out  (car1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Launches one add at the current negedge and follows it to the done cycle.
    // With inject set, a second start (0x01+0x01) is pulsed while RUN is in progress.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input bit inject);
        logic [8:0] full;
        full  = {1'b0, ta} + {1'b0, tb_v} + {8'h00, tc};
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        c     = tc;
        for (int i = 0; i <= 8; i++) begin
            step();
            check("busy", 32'(busy), 32'(i < 8));
            check("done", 32'(done), 32'(i == 8));
            if (i < 8) begin
                check("sum_hold", 32'(sum), 32'(exp_sum));
                check("car_hold", 32'(car), 32'(exp_car));
            end else begin
                check("sum", 32'(sum), 32'(full[7:0]));
                check("car", 32'(car), 32'(full[8]));
                exp_sum = full[7:0];
                exp_car = full[8];
            end
            start = inject && (i == 3);
            if (start) begin
                a = 8'h01;
                b = 8'h01;
                c = 1'b0;
            end else begin
                a = 8'($urandom_range(255));
                b = 8'($urandom_range(255));
                c = 1'($urandom_range(1));
            end
        end
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_sum", 32'(sum), 32'(exp_sum));
        end
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        c      = 1'b0;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        c1     = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_car", 32'(car), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // Directed cases.
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        check("sum_5a3c", 32'(sum), 32'h96);
        idle_cycles(1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        idle_cycles(1);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        idle_cycles(1);

        // Start pulsed mid-RUN must be dropped.
        run_op(8'h77, 8'h19, 1'b1, 1'b1);
        idle_cycles(3);

        // Random operands with gaps of 0..2; a gap of 0 starts in the DONE cycle.
        for (int n = 0; n < 25; n++) begin
            run_op(8'($urandom_range(255)), 8'($urandom_range(255)),
                   1'($urandom_range(1)), 1'b0);
            idle_cycles(int'($urandom_range(2)));
        end
        idle_cycles(1);

        // Start held high: one result every WIDTH+1 cycles.
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h20;
        c     = 1'b0;
        for (int cyc = 0; cyc < 36; cyc++) begin
            step();
            check("cont_done", 32'(done), 32'((cyc >= 8) && ((cyc - 8) % 9 == 0)));
            if (cyc >= 8) check("cont_sum", 32'(sum), 32'h30);
            else          check("cont_sum_old", 32'(sum), 32'(exp_sum));
        end
        start   = 1'b0;
        exp_sum = 8'h30;
        exp_car = 1'b0;
        idle_cycles(2);

        // Asynchronous reset in the middle of RUN.
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        c     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_car", 32'(car), 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        exp_sum = 8'h00;
        exp_car = 1'b0;
        idle_cycles(12);
        run_op(8'h0F, 8'h01, 1'b0, 1'b0);
        check("post_rst_sum", 32'(sum), 32'h10);
        idle_cycles(1);

        // WIDTH=1 instance: every input combination, done one edge after acceptance.
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            logic [1:0] r;
            v      = 3'(k);
            r      = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            a1     = v[2];
            b1     = v[1];
            c1     = v[0];
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            check("w1_busy", 32'(busy1), 32'd1);
            check("w1_done_e0", 32'(done1), 32'd0);
            step();
            check("w1_done", 32'(done1), 32'd1);
            check("w1_busy_e1", 32'(busy1), 32'd0);
            check("w1_sum", 32'(sum1), 32'(r[0]));
            check("w1_car", 32'(car1), 32'(r[1]));
            step();
            check("w1_done_off", 32'(done1), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
